// File: rtl/poly_nco.sv
// Time-multiplexed phase-accumulator NCO: one tick sweeps all voices, one voice per clock.
// Voice v output registered k+1+v edges after the tick edge; ticks while busy are dropped and flagged.
module poly_nco #(
  parameter int N_VOICES = 8,
  parameter int VIDX_W   = 3,
  parameter int ACC_W    = 24,
  parameter int ADDR_W   = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              sample_tick,
  input  logic              cfg_we,
  input  logic [VIDX_W-1:0] cfg_voice,
  input  logic [ACC_W-1:0]  cfg_tw,
  input  logic              cfg_en,
  input  logic              cfg_sync,
  output logic              out_valid,
  output logic [VIDX_W-1:0] out_voice,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_wrap,
  output logic              busy,
  output logic              overrun
);

  localparam logic [0:0]        S_IDLE   = 1'b0;
  localparam logic [0:0]        S_SWEEP  = 1'b1;
  localparam logic [VIDX_W-1:0] LAST_IDX = VIDX_W'(N_VOICES - 1);

  logic [0:0]        state_q, state_d;
  logic [VIDX_W-1:0] idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [VIDX_W-1:0] out_voice_q, out_voice_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_wrap_q, out_wrap_d;
  logic              overrun_q, overrun_d;

  logic [ACC_W-1:0]    acc_q [N_VOICES];
  logic [ACC_W-1:0]    tw_q  [N_VOICES];
  logic [N_VOICES-1:0] en_q;

  logic             sweeping;
  logic             slot_sync;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] new_acc;

  always_comb begin
    sweeping  = (state_q == S_SWEEP);
    // A sync aimed at the slot being processed overrides that slot's update.
    slot_sync = sweeping && cfg_sync && (cfg_voice == idx_q);
    sum       = {1'b0, acc_q[idx_q]} + {1'b0, tw_q[idx_q]};
    new_acc   = en_q[idx_q] ? sum[ACC_W-1:0] : acc_q[idx_q];
    if (slot_sync) begin
      new_acc = '0;
    end

    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = 1'b0;
    out_voice_d = out_voice_q;
    out_addr_d  = out_addr_q;
    out_wrap_d  = out_wrap_q;
    overrun_d   = overrun_q | (sample_tick & sweeping);

    if (sweeping) begin
      out_valid_d = 1'b1;
      out_voice_d = idx_q;
      out_addr_d  = new_acc[ACC_W-1 -: ADDR_W];
      out_wrap_d  = en_q[idx_q] & sum[ACC_W] & ~slot_sync;
      if (idx_q == LAST_IDX) begin
        state_d = S_IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (sample_tick) begin
      state_d = S_SWEEP;
      idx_d   = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_voice_q <= '0;
      out_addr_q  <= '0;
      out_wrap_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_voice_q <= out_voice_d;
      out_addr_q  <= out_addr_d;
      out_wrap_q  <= out_wrap_d;
      overrun_q   <= overrun_d;
    end
  end

  // Out-of-range cfg_voice values match no slot, so such writes and syncs fall away.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int v = 0; v < N_VOICES; v++) begin
        acc_q[v] <= '0;
        tw_q[v]  <= '0;
      end
      en_q <= '0;
    end else begin
      for (int v = 0; v < N_VOICES; v++) begin
        if (cfg_sync && (cfg_voice == VIDX_W'(v))) begin
          acc_q[v] <= '0;
        end else if (sweeping && (idx_q == VIDX_W'(v))) begin
          acc_q[v] <= new_acc;
        end
        if (cfg_we && (cfg_voice == VIDX_W'(v))) begin
          tw_q[v] <= cfg_tw;
          en_q[v] <= cfg_en;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_voice = out_voice_q;
  assign out_addr  = out_addr_q;
  assign out_wrap  = out_wrap_q;
  assign busy      = (state_q == S_SWEEP);
  assign overrun   = overrun_q;

endmodule

// File: doc/poly_nco.md
Name: poly_nco

Overview:
- Time-multiplexed, multi-voice phase-accumulator NCO; successor to the single-voice divider NCO.
- One sample_tick starts a sweep that advances every voice's phase accumulator by its tuning word, one voice per clock.
- Each sweep emits one wavetable address per voice to the wavetable/mixer stage.
- Per-voice tuning word, gate enable, and hard-sync phase reset are written through a config port.

Parameters:
N_VOICES, 8, number of voices (2..2^VIDX_W)
VIDX_W, 3, voice index width; 2^VIDX_W >= N_VOICES
ACC_W, 24, phase accumulator and tuning word width
ADDR_W, 8, wavetable address width (ADDR_W <= ACC_W); address = acc[ACC_W-1 -: ADDR_W]

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  synchronous active-low reset
sample_tick  in  1  one-cycle strobe, starts a sweep
cfg_we  in  1  write tuning word and enable for cfg_voice
cfg_voice  in  VIDX_W  target voice for cfg_we / cfg_sync
cfg_tw  in  ACC_W  tuning word (phase increment per sweep)
cfg_en  in  1  voice gate written with cfg_we
cfg_sync  in  1  zero phase accumulator of cfg_voice
out_valid  out  1  out_voice/out_addr/out_wrap valid this cycle
out_voice  out  VIDX_W  voice index of current output
out_addr  out  ADDR_W  wavetable address for out_voice
out_wrap  out  1  accumulator overflowed on this update
busy  out  1  sweep in progress
overrun  out  1  sticky: sample_tick arrived while busy

Behaviour:
- Reset (sys_rst_n=0 at an edge):
  - all accumulators, tuning words and enables are 0; state IDLE; voice index 0.
  - out_valid, out_voice, out_addr, out_wrap, busy, overrun are all 0.
  - Reset mid-sweep aborts the sweep; no further out_valid.
- States: IDLE, SWEEP.
  - IDLE: sample_tick=1 at edge k -> SWEEP with idx=0; busy=1 from edge k.
  - SWEEP: each edge processes voice idx, then idx+1. The edge that processes idx=N_VOICES-1 returns to IDLE; busy=0 after that edge.
  - A sweep occupies exactly N_VOICES cycles.
- Per-voice update (registered, at the processing edge):
  - en=1: acc <= (acc + tw) mod 2^ACC_W; out_wrap=1 iff the add carried out.
  - en=0: acc held; out_wrap=0.
  - out_addr = top ADDR_W bits of the new (or held) acc; out_voice=idx; out_valid=1 for that cycle only.
- Latency:
  - Tick at edge k gives voice 0 valid after edge k+1, voice v valid after edge k+1+v.
  - out_valid is high on N_VOICES consecutive cycles per sweep.
- Overrun:
  - sample_tick while busy=1 (including the last-voice cycle) is ignored and sets overrun=1.
  - overrun clears only on reset.
  - Tick in IDLE the cycle after the sweep ends is accepted normally.
- Config:
  - cfg_we updates tw/en of cfg_voice at the edge; the voice uses the new values from its next processing slot.
  - A write to the voice being processed in the same cycle: this slot uses the old tw/en.
  - cfg_voice >= N_VOICES: write and sync are ignored.
- Sync:
  - cfg_sync sets acc of cfg_voice to 0 at the edge.
  - Sync to the voice being processed in the same cycle: sync wins; stored acc=0, out_addr=0, out_wrap=0, out_valid still 1.
  - cfg_we and cfg_sync together: both take effect.
- Idle outputs: out_valid=0; out_voice/out_addr/out_wrap hold their last values.
- Width rules:
  - Accumulator addition is unsigned and truncating.
  - tw=0 with en=1 holds phase with out_valid still asserted.

Test Plan:
- Reset: hold sys_rst_n=0 for 2 cycles, then release with no tick -> all outputs 0, busy=0, overrun=0, no out_valid.
- Single voice, N_VOICES=8, ACC_W=24, ADDR_W=8, cfg voice 0 tw=0x010000 en=1, then one tick:
  - out_valid on 8 consecutive cycles, voice order 0..7.
  - voice 0 out_addr=0x01; voices 1-7 out_addr=0x00.
  - busy high for exactly 8 cycles.
- Wrap, continuing the same config: 256 ticks total -> on tick 256 voice 0 out_addr=0x00 with out_wrap=1; no other voice ever flags wrap.
- Gate off: voice 2 tw=0x400000 en=1, 1 tick (addr 0x40), then write en=0 and give 3 ticks -> voice 2 out_addr stays 0x40, out_wrap=0, out_valid still asserted in its slot.
- Collision, voice 3 tw=0x100000 en=1 with acc at 0x300000:
  - pulse cfg_sync for voice 3 on its processing cycle -> out_addr=0x00 reported.
  - next sweep reports out_addr=0x10.
- Overrun/abort:
  - tick during sweep cycle 4 -> overrun=1 and sweep length unchanged.
  - a fresh tick then reset asserted at sweep cycle 3 -> busy=0 and overrun=0 after the reset edge; no out_valid afterwards.
